pipeline_hazard_ctrl: RTL and testbench

//  Pipeline sequencer beside the main decoder: generates stall/flush/bubble controls for the 5-stage RISC-V core.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_perf_cnt.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard sequencer.
//   hz_state_e : sequencer states (RUN, MEM_WAIT, DRAIN, HALTED)
//   REG_ZERO   : index of the hard-wired zero register
//   OPC_*      : RV32I major opcodes shared with the main decoder
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hz_state_e;

    localparam int unsigned REG_ZERO = 0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: pair of saturating event counters.
// Built only when HAZARD_PERF_EN is defined.
//   clk      in   core clock
//   rst      in   asynchronous active-high reset, clears both counters
//   freeze_i in   hold both counters
//   inc_a_i  in   increment counter A this cycle
//   inc_b_i  in   increment counter B this cycle
//   cnt_a_o  out  counter A (saturates at all-ones)
//   cnt_b_o  out  counter B (saturates at all-ones)
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze_i,
    input  logic             inc_a_i,
    input  logic             inc_b_i,
    output logic [CNT_W-1:0] cnt_a_o,
    output logic [CNT_W-1:0] cnt_b_o
);

    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else if (!freeze_i) begin
            if (inc_a_i && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + 1'b1;
            if (inc_b_i && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + 1'b1;
        end
    end

    assign cnt_a_o = cnt_a_q;
    assign cnt_b_o = cnt_b_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble sequencer for the 5-stage RISC-V core.
// Handles load-use stalls, EX-stage redirects, data-memory waits with timeout
// and the HALT drain sequence.
// Optional feature macro: HAZARD_PERF_EN (builds stall/flush perf counters;
// otherwise stall_cnt/flush_cnt read 0).
// Ports:
//   clk, reset          core clock, asynchronous active-high reset
//   id_rs1/id_rs2       ID source registers, id_use_rs1/id_use_rs2 their use flags
//   id_halt             ID instruction is HALT
//   ex_mem_read, ex_rd  load in EX and its destination
//   ex_redirect         EX resolves taken branch / JAL / JALR
//   mem_req, dmem_ready MEM stage access and data-memory completion
//   pc_stall .. mem_wb_bubble  combinational pipeline controls
//   halted, mem_err     registered status (mem_err sticky until reset)
//   stall_cnt/flush_cnt perf counters
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_halt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              dmem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              mem_wb_bubble,
    output logic              halted,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DRN_W  = $clog2(DRAIN_CYCLES + 1);

    hz_state_e         state_q, state_d;
    logic              ret_drain_q, ret_drain_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              halted_q, halted_d;
    logic              mem_err_q, mem_err_d;

    logic memwait, in_drain, load_use;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c;
    logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c, mem_wb_bubble_c;

    always_comb begin
        memwait  = mem_req & ~dmem_ready & (state_q != HALTED);
        // MEM_WAIT entered from DRAIN resumes draining on the release cycle.
        in_drain = (state_q == DRAIN) | ((state_q == MEM_WAIT) & ret_drain_q);
        load_use = ex_mem_read & (ex_rd != REG_AW'(REG_ZERO)) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_stall_c   = 1'b0;
        id_ex_flush_c   = 1'b0;
        ex_mem_stall_c  = 1'b0;
        mem_wb_bubble_c = 1'b0;

        state_d     = state_q;
        ret_drain_d = ret_drain_q;
        wait_d      = wait_q;
        drain_d     = drain_q;
        halted_d    = halted_q;
        mem_err_d   = mem_err_q;

        if (state_q == HALTED) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_stall_c   = 1'b1;
            ex_mem_stall_c  = 1'b1;
            mem_wb_bubble_c = 1'b1;
        end else if (memwait) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_stall_c   = 1'b1;
            ex_mem_stall_c  = 1'b1;
            mem_wb_bubble_c = 1'b1;
            if (state_q == MEM_WAIT) begin
                // wait_q already counts the entry cycle, so this is wait cycle wait_q+1.
                if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end else begin
                state_d     = MEM_WAIT;
                ret_drain_d = (state_q == DRAIN);
                wait_d      = WAIT_W'(1);
            end
        end else begin
            wait_d      = '0;
            ret_drain_d = 1'b0;
            if (in_drain) begin
                pc_stall_c    = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                if (drain_q <= DRN_W'(1)) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    drain_d  = '0;
                end else begin
                    state_d = DRAIN;
                    drain_d = drain_q - 1'b1;
                end
            end else begin
                state_d = RUN;
                if (ex_redirect) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (id_halt) begin
                    pc_stall_c    = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    state_d       = DRAIN;
                    drain_d       = DRN_W'(DRAIN_CYCLES);
                end else if (load_use) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            ret_drain_q <= 1'b0;
            wait_q      <= '0;
            drain_q     <= '0;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
            wait_q      <= wait_d;
            drain_q     <= drain_d;
            halted_q    <= halted_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign pc_stall      = pc_stall_c      & ~reset;
    assign if_id_stall   = if_id_stall_c   & ~reset;
    assign if_id_flush   = if_id_flush_c   & ~reset;
    assign id_ex_stall   = id_ex_stall_c   & ~reset;
    assign id_ex_flush   = id_ex_flush_c   & ~reset;
    assign ex_mem_stall  = ex_mem_stall_c  & ~reset;
    assign mem_wb_bubble = mem_wb_bubble_c & ~reset;
    assign halted        = halted_q;
    assign mem_err       = mem_err_q;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk      (clk),
        .rst      (reset),
        .freeze_i (state_q == HALTED),
        .inc_a_i  (pc_stall),
        .inc_b_i  (if_id_flush),
        .cnt_a_o  (stall_cnt),
        .cnt_b_o  (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned CNT_W = 32;
    // Control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, mem_wb_bubble
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_RD   = 7'b0010100;
    localparam logic [6:0] C_HALT = 7'b1010100;
    localparam logic [6:0] C_WAIT = 7'b1101011;
`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] EXP_STALL = 32'd3;
    localparam logic [CNT_W-1:0] EXP_FLUSH = 32'd2;
`else
    localparam logic [CNT_W-1:0] EXP_STALL = 32'd0;
    localparam logic [CNT_W-1:0] EXP_FLUSH = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, id_halt, ex_mem_read, ex_redirect, mem_req, dmem_ready;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble;
    logic halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0] ctl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble};

    pipeline_hazard_ctrl #(
        .REG_AW(5), .DRAIN_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .halted(halted), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_halt = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    // Inputs are driven just after posedge; outputs are checked at negedge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        mem_req = 1'b1; dmem_ready = 1'b0; id_halt = 1'b1;
        @(negedge clk);
        tests++;
        if (ctl !== C_NONE || halted !== 1'b0 || mem_err !== 1'b0) begin
            $display("FAIL reset_hold: ctl=%b halted=%b mem_err=%b expected ctl=%b halted=0 mem_err=0", ctl, halted, mem_err, C_NONE);
            fails++;
        end
        idle();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        @(negedge clk);
        tests++;
        if (ctl !== C_NONE || halted !== 1'b0 || mem_err !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
            $display("FAIL reset_state: ctl=%b halted=%b mem_err=%b stall=%0d flush=%0d expected all 0", ctl, halted, mem_err, stall_cnt, flush_cnt);
            fails++;
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        // load x5 in EX, ID add x6,x5,x1
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_LU) begin $display("FAIL lu_rs1: ctl=%b expected %b", ctl, C_LU); fails++; end
        next_cycle();
        ex_mem_read = 1'b0; ex_rd = '0;
        @(negedge clk); tests++;
        if (ctl !== C_NONE) begin $display("FAIL lu_after_bubble: ctl=%b expected %b", ctl, C_NONE); fails++; end
        next_cycle();
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd2; id_rs2 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_LU) begin $display("FAIL lu_rs2: ctl=%b expected %b", ctl, C_LU); fails++; end
        next_cycle();
        id_use_rs2 = 1'b0;
        @(negedge clk); tests++;
        if (ctl !== C_NONE) begin $display("FAIL lu_rs2_unused: ctl=%b expected %b", ctl, C_NONE); fails++; end
        next_cycle();
        ex_mem_read = 1'b0; id_rs1 = 5'd7;
        @(negedge clk); tests++;
        if (ctl !== C_NONE) begin $display("FAIL lu_not_load: ctl=%b expected %b", ctl, C_NONE); fails++; end
        next_cycle();
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_LU) begin $display("FAIL lu_third: ctl=%b expected %b", ctl, C_LU); fails++; end
        next_cycle();
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_NONE) begin $display("FAIL lu_x0: ctl=%b expected %b", ctl, C_NONE); fails++; end
        next_cycle();
    endtask

    task automatic test_redirect();
        idle(); ex_redirect = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_RD) begin $display("FAIL redirect: ctl=%b expected %b", ctl, C_RD); fails++; end
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1; id_halt = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_RD) begin $display("FAIL redirect_over_lu_halt: ctl=%b expected %b", ctl, C_RD); fails++; end
        next_cycle();
        idle();
        @(negedge clk); tests++;
        if (ctl !== C_NONE || halted !== 1'b0) begin
            $display("FAIL redirect_after: ctl=%b halted=%b expected %b halted=0", ctl, halted, C_NONE); fails++;
        end
    endtask

    task automatic test_perf();
        @(negedge clk); tests++;
        if (stall_cnt !== EXP_STALL || flush_cnt !== EXP_FLUSH) begin
            $display("FAIL perf_counts: stall=%0d flush=%0d expected stall=%0d flush=%0d", stall_cnt, flush_cnt, EXP_STALL, EXP_FLUSH);
            fails++;
        end
        next_cycle();
    endtask

    task automatic test_memwait();
        idle(); mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // a load-use in ID must not change the memwait controls
            ex_mem_read = (i == 2); ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
            @(negedge clk); tests++;
            if (ctl !== C_WAIT) begin $display("FAIL memwait_c%0d: ctl=%b expected %b", i, ctl, C_WAIT); fails++; end
            next_cycle();
        end
        idle(); mem_req = 1'b1; dmem_ready = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_NONE) begin $display("FAIL memwait_release: ctl=%b expected %b", ctl, C_NONE); fails++; end
        next_cycle();
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs2 = 5'd8; id_use_rs2 = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_LU || halted !== 1'b0) begin
            $display("FAIL memwait_back_in_run: ctl=%b halted=%b expected %b halted=0", ctl, halted, C_LU); fails++;
        end
        next_cycle();
        idle();
    endtask

    task automatic test_halt_drain();
        logic [6:0] exp_ctl [6];
        exp_ctl[0] = C_HALT; exp_ctl[1] = C_HALT; exp_ctl[2] = C_WAIT;
        exp_ctl[3] = C_WAIT; exp_ctl[4] = C_HALT; exp_ctl[5] = C_HALT;
        for (int i = 0; i < 6; i++) begin
            idle();
            id_halt     = (i == 0);
            ex_redirect = (i == 1);
            mem_req     = (i == 2 || i == 3 || i == 4);
            dmem_ready  = !(i == 2 || i == 3);
            @(negedge clk); tests++;
            if (ctl !== exp_ctl[i] || halted !== 1'b0) begin
                $display("FAIL drain_c%0d: ctl=%b halted=%b expected %b halted=0", i, ctl, halted, exp_ctl[i]); fails++;
            end
            next_cycle();
        end
        idle(); ex_redirect = 1'b1; id_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); tests++;
            if (ctl !== C_WAIT || halted !== 1'b1 || mem_err !== 1'b0) begin
                $display("FAIL halted_hold_%0d: ctl=%b halted=%b mem_err=%b expected %b halted=1 mem_err=0", i, ctl, halted, mem_err, C_WAIT); fails++;
            end
            next_cycle();
        end
        do_reset();
        @(negedge clk); tests++;
        if (ctl !== C_NONE || halted !== 1'b0) begin
            $display("FAIL halt_reset: ctl=%b halted=%b expected %b halted=0", ctl, halted, C_NONE); fails++;
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int early_bad = 0;
        idle(); mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ctl !== C_WAIT || halted !== 1'b0 || mem_err !== 1'b0) early_bad++;
            next_cycle();
        end
        tests++;
        if (early_bad != 0) begin
            $display("FAIL timeout_wait_phase: %0d bad cycles, expected 0", early_bad); fails++;
        end
        idle();
        @(negedge clk); tests++;
        if (mem_err !== 1'b1 || halted !== 1'b1 || ctl !== C_WAIT) begin
            $display("FAIL timeout_err: mem_err=%b halted=%b ctl=%b expected 1 1 %b", mem_err, halted, ctl, C_WAIT); fails++;
        end
        next_cycle();
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        @(negedge clk); tests++;
        if (mem_err !== 1'b0 || halted !== 1'b0 || ctl !== C_LU) begin
            $display("FAIL timeout_reset: mem_err=%b halted=%b ctl=%b expected 0 0 %b", mem_err, halted, ctl, C_LU); fails++;
        end
        next_cycle();
        idle();
    endtask

    task automatic test_timeout_boundary();
        // 63 wait cycles then ready: must not raise mem_err
        idle(); mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (63) next_cycle();
        dmem_ready = 1'b1;
        @(negedge clk); tests++;
        if (ctl !== C_NONE || mem_err !== 1'b0 || halted !== 1'b0) begin
            $display("FAIL timeout_boundary: ctl=%b mem_err=%b halted=%b expected %b 0 0", ctl, mem_err, halted, C_NONE); fails++;
        end
        next_cycle();
        idle();
        @(negedge clk); tests++;
        if (mem_err !== 1'b0 || halted !== 1'b0) begin
            $display("FAIL timeout_boundary_after: mem_err=%b halted=%b expected 0 0", mem_err, halted); fails++;
        end
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_redirect();
        test_perf();
        test_memwait();
        test_timeout_boundary();
        test_halt_drain();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
